// File: rtl/shift_logic_unit_pkg.sv
// Shared definitions for the shift/logic unit: opcode map, flag bundle and
// the decode from opcode to barrel-shifter controls.
package shift_logic_unit_pkg;

    localparam logic [3:0] OP_AND = 4'd0;
    localparam logic [3:0] OP_OR  = 4'd1;
    localparam logic [3:0] OP_XOR = 4'd2;
    localparam logic [3:0] OP_SLL = 4'd3;
    localparam logic [3:0] OP_SRL = 4'd4;
    localparam logic [3:0] OP_SLA = 4'd5;
    localparam logic [3:0] OP_SRA = 4'd6;
    localparam logic [3:0] OP_ROL = 4'd7;
    localparam logic [3:0] OP_ROR = 4'd8;

    typedef struct packed {
        logic zf;
        logic nf;
        logic cf;
    } flags_t;

    typedef struct packed {
        logic is_shift;
        logic dir;      // 0 = left, 1 = right
        logic arith;    // sign-fill on right shifts
        logic rotate;
    } shift_ctrl_t;

    // SLA is a plain zero-filling left shift, so it decodes exactly like SLL.
    function automatic shift_ctrl_t decode_shift(input logic [3:0] op);
        shift_ctrl_t c;
        c = '0;
        case (op)
            OP_SLL, OP_SLA: c.is_shift = 1'b1;
            OP_SRL: begin c.is_shift = 1'b1; c.dir = 1'b1; end
            OP_SRA: begin c.is_shift = 1'b1; c.dir = 1'b1; c.arith = 1'b1; end
            OP_ROL: begin c.is_shift = 1'b1; c.rotate = 1'b1; end
            OP_ROR: begin c.is_shift = 1'b1; c.rotate = 1'b1; c.dir = 1'b1; end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic logic is_reserved(input logic [3:0] op);
        return op > OP_ROR;
    endfunction

endpackage

// File: rtl/barrel_shifter.sv
// Combinational shifter/rotator. cf is the last bit shifted out for shifts
// and the bit that wrapped into the LSB/MSB for rotates; a zero shift
// amount always returns a unchanged with cf clear.
module barrel_shifter #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0]         a,
    input  logic [$clog2(WIDTH)-1:0] shamt,
    input  logic                     dir,
    input  logic                     arith,
    input  logic                     rotate,
    output logic [WIDTH-1:0]         result,
    output logic                     cf
);

    localparam int SHAMT_W = $clog2(WIDTH);
    localparam logic [SHAMT_W:0] WIDTH_V = (SHAMT_W + 1)'(WIDTH);

    logic [SHAMT_W:0] inv_amt;
    logic [WIDTH:0]   left_ext;
    logic [WIDTH:0]   right_ext;
    logic [WIDTH-1:0] rot_left;
    logic [WIDTH-1:0] rot_right;

    // One extra bit on each side of the operand catches the last bit shifted out.
    always_comb begin
        result  = a;
        cf      = 1'b0;
        inv_amt = WIDTH_V - {1'b0, shamt};
        left_ext = {1'b0, a} << shamt;
        if (arith) begin
            right_ext = $signed({a, 1'b0}) >>> shamt;
        end else begin
            right_ext = {a, 1'b0} >> shamt;
        end
        rot_left  = (a << shamt) | (a >> inv_amt);
        rot_right = (a >> shamt) | (a << inv_amt);
        if (rotate) begin
            result = dir ? rot_right : rot_left;
            cf     = (shamt != '0) & (dir ? rot_right[WIDTH-1] : rot_left[0]);
        end else if (dir) begin
            result = right_ext[WIDTH:1];
            cf     = right_ext[0];
        end else begin
            result = left_ext[WIDTH-1:0];
            cf     = left_ext[WIDTH];
        end
    end

endmodule

// File: rtl/shift_logic_unit.sv
// Two-stage shift/logic unit with valid/ready handshakes on both sides.
// S1 captures the operation; S2 computes it and holds the registered result
// until the consumer takes it. enable=0 freezes everything.
module shift_logic_unit
    import shift_logic_unit_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int TAG_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_zf,
    output logic             out_nf,
    output logic             out_cf,
    output logic             out_illegal
);

    localparam int SHAMT_W = $clog2(WIDTH);

    logic             s1_valid;
    logic [3:0]       s1_op;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [TAG_W-1:0] s1_tag;

    logic             s2_advance;
    shift_ctrl_t      s2_ctrl;
    logic [WIDTH-1:0] sh_result;
    logic             sh_cf;
    logic [WIDTH-1:0] s2_result;
    logic             s2_cf;
    logic             s2_illegal;
    flags_t           s2_flags;

    assign s2_advance = !out_valid || out_ready;
    assign in_ready   = enable && (!s1_valid || s2_advance);
    assign s2_ctrl    = decode_shift(s1_op);

    // S1: take a new operation whenever the slot is free or draining this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_op    <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_tag   <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_op  <= in_op;
                s1_a   <= in_a;
                s1_b   <= in_b;
                s1_tag <= in_tag;
            end
        end
    end

    barrel_shifter #(
        .WIDTH (WIDTH)
    ) u_barrel_shifter (
        .a      (s1_a),
        .shamt  (s1_b[SHAMT_W-1:0]),
        .dir    (s2_ctrl.dir),
        .arith  (s2_ctrl.arith),
        .rotate (s2_ctrl.rotate),
        .result (sh_result),
        .cf     (sh_cf)
    );

    // S2 datapath: pick logic or shifter result, derive flags; reserved ops yield zero.
    always_comb begin
        s2_result  = '0;
        s2_cf      = 1'b0;
        s2_illegal = is_reserved(s1_op);
        case (s1_op)
            OP_AND:  s2_result = s1_a & s1_b;
            OP_OR:   s2_result = s1_a | s1_b;
            OP_XOR:  s2_result = s1_a ^ s1_b;
            default: begin
                if (s2_ctrl.is_shift) begin
                    s2_result = sh_result;
                    s2_cf     = sh_cf;
                end
            end
        endcase
        s2_flags.zf = (s2_result == '0);
        s2_flags.nf = s2_result[WIDTH-1];
        s2_flags.cf = s2_cf;
    end

    // S2 output register: holds while the consumer stalls; only loads real operations.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_result  <= '0;
            out_tag     <= '0;
            out_zf      <= 1'b0;
            out_nf      <= 1'b0;
            out_cf      <= 1'b0;
            out_illegal <= 1'b0;
        end else if (enable && s2_advance) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_result  <= s2_result;
                out_tag     <= s1_tag;
                out_zf      <= s2_flags.zf;
                out_nf      <= s2_flags.nf;
                out_cf      <= s2_flags.cf;
                out_illegal <= s2_illegal;
            end
        end
    end

endmodule

// File: tb/tb_shift_logic_unit.sv
// Bench for shift_logic_unit: directed vectors at 16 and 32 bits, a
// backpressure sequence, a mid-flight reset, then randomized traffic checked
// against an in-order queue of expected results.
module tb_shift_logic_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;

    logic        in_valid, in_ready, out_valid, out_ready;
    logic [3:0]  in_op;
    logic [15:0] in_a, in_b, out_result;
    logic [2:0]  in_tag, out_tag;
    logic        out_zf, out_nf, out_cf, out_illegal;

    logic        in_valid_32, in_ready_32, out_valid_32, out_ready_32;
    logic [3:0]  in_op_32;
    logic [31:0] in_a_32, in_b_32, out_result_32;
    logic [2:0]  in_tag_32, out_tag_32;
    logic        out_zf_32, out_nf_32, out_cf_32, out_illegal_32;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [15:0] res;
        logic [2:0]  tag;
        logic [3:0]  fl;   // {illegal, zf, nf, cf}
        int          age;  // enabled clock edges seen since (and including) accept
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    shift_logic_unit #(.WIDTH(16), .TAG_W(3)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_tag(out_tag), .out_zf(out_zf), .out_nf(out_nf), .out_cf(out_cf),
        .out_illegal(out_illegal)
    );

    shift_logic_unit #(.WIDTH(32), .TAG_W(3)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .in_valid(in_valid_32), .in_ready(in_ready_32), .in_op(in_op_32),
        .in_a(in_a_32), .in_b(in_b_32), .in_tag(in_tag_32),
        .out_valid(out_valid_32), .out_ready(out_ready_32), .out_result(out_result_32),
        .out_tag(out_tag_32), .out_zf(out_zf_32), .out_nf(out_nf_32), .out_cf(out_cf_32),
        .out_illegal(out_illegal_32)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: each result bit computed directly from the opcode definitions.
    function automatic logic [19:0] ref_model(input logic [3:0] op, input logic [15:0] a,
                                              input logic [15:0] b);
        logic [15:0] r;
        logic        cf, ill;
        int          sh;
        r = '0; cf = 1'b0; ill = 1'b0;
        sh = int'(b[3:0]);
        case (op)
            4'd0: r = a & b;
            4'd1: r = a | b;
            4'd2: r = a ^ b;
            4'd3, 4'd5: begin
                for (int i = 0; i < 16; i++) if (i >= sh) r[i] = a[i-sh];
                if (sh > 0) cf = a[16-sh];
            end
            4'd4, 4'd6: begin
                for (int i = 0; i < 16; i++) begin
                    if (i + sh < 16) r[i] = a[i+sh];
                    else             r[i] = (op == 4'd6) ? a[15] : 1'b0;
                end
                if (sh > 0) cf = a[sh-1];
            end
            4'd7: begin
                for (int i = 0; i < 16; i++) r[(i+sh)%16] = a[i];
                if (sh > 0) cf = r[0];
            end
            4'd8: begin
                for (int i = 0; i < 16; i++) r[i] = a[(i+sh)%16];
                if (sh > 0) cf = r[15];
            end
            default: ill = 1'b1;
        endcase
        return {ill, (r == 16'd0), r[15], cf, r};
    endfunction

    // One cycle of the randomized/streaming checker; entered and left at posedge+1.
    task automatic step();
        logic        exp_rdy, exp_vld;
        logic [19:0] m;
        exp_t        e;
        @(negedge clk);
        exp_rdy = enable && !(sb.size() == 2 && !out_ready);
        exp_vld = 1'b0;
        if (sb.size() > 0) exp_vld = (sb[0].age >= 2);
        check_eq("in_ready", in_ready, exp_rdy);
        check_eq("out_valid", out_valid, exp_vld);
        if (exp_vld) begin
            check_eq("out_result", out_result, sb[0].res);
            check_eq("out_tag", out_tag, sb[0].tag);
            check_eq("out_flags", {out_illegal, out_zf, out_nf, out_cf}, sb[0].fl);
            if (enable && out_ready) void'(sb.pop_front());
        end
        if (in_valid && exp_rdy) begin
            m = ref_model(in_op, in_a, in_b);
            e.res = m[15:0]; e.fl = m[19:16]; e.tag = in_tag; e.age = 0;
            sb.push_back(e);
        end
        if (enable) foreach (sb[k]) sb[k].age = sb[k].age + 1;
        @(posedge clk); #1;
    endtask

    // Single operation on an empty 16-bit pipe, checked against spelled-out values.
    task automatic dir16(input string nm, input logic [3:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [2:0] tag,
                         input logic [15:0] er, input logic [3:0] ef);
        enable = 1'b1; out_ready = 1'b1;
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
        @(negedge clk);
        check_eq({nm, "_in_ready"}, in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_eq({nm, "_valid"}, out_valid, 1'b1);
        check_eq({nm, "_result"}, out_result, er);
        check_eq({nm, "_tag"}, out_tag, tag);
        check_eq({nm, "_flags"}, {out_illegal, out_zf, out_nf, out_cf}, ef);
        @(posedge clk); #1;
    endtask

    task automatic dir32(input string nm, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] er, input logic [3:0] ef);
        enable = 1'b1; out_ready_32 = 1'b1;
        in_valid_32 = 1'b1; in_op_32 = op; in_a_32 = a; in_b_32 = b; in_tag_32 = 3'd2;
        @(posedge clk); #1;
        in_valid_32 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_eq({nm, "_valid"}, out_valid_32, 1'b1);
        check_eq({nm, "_result"}, out_result_32, er);
        check_eq({nm, "_flags"}, {out_illegal_32, out_zf_32, out_nf_32, out_cf_32}, ef);
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b1;
        in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b1;
        in_valid_32 = 1'b0; in_op_32 = '0; in_a_32 = '0; in_b_32 = '0; in_tag_32 = '0;
        out_ready_32 = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_out_result", out_result, 16'h0);
        check_eq("rst_out_tag", out_tag, 3'd0);
        check_eq("rst_flags", {out_illegal, out_zf, out_nf, out_cf}, 4'b0000);
        check_eq("rst_in_ready", in_ready, 1'b1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // flags order {illegal, zf, nf, cf}
        dir16("and",  4'd0,  16'h13ab, 16'h14cc, 3'd1, 16'h1088, 4'b0000);
        dir16("or",   4'd1,  16'h13ab, 16'h14cc, 3'd2, 16'h17ef, 4'b0000);
        dir16("xor",  4'd2,  16'h13ab, 16'h14cc, 3'd3, 16'h0767, 4'b0000);
        dir16("sll",  4'd3,  16'h8001, 16'h0002, 3'd4, 16'h0004, 4'b0000);
        dir16("sla",  4'd5,  16'h8001, 16'h0002, 3'd4, 16'h0004, 4'b0000);
        dir16("srl",  4'd4,  16'h8001, 16'h0002, 3'd5, 16'h2000, 4'b0000);
        dir16("sra",  4'd6,  16'h8001, 16'h0002, 3'd6, 16'he000, 4'b0010);
        dir16("rol",  4'd7,  16'h8001, 16'h0002, 3'd7, 16'h0006, 4'b0000);
        dir16("ror",  4'd8,  16'h8001, 16'h0002, 3'd0, 16'h6000, 4'b0000);
        dir16("srl0", 4'd4,  16'h8001, 16'hfff0, 3'd1, 16'h8001, 4'b0010);
        dir16("srl1", 4'd4,  16'h8001, 16'h0001, 3'd1, 16'h4000, 4'b0001);
        dir16("rol1", 4'd7,  16'h8001, 16'h0001, 3'd1, 16'h0003, 4'b0001);
        dir16("ill",  4'd12, 16'hffff, 16'h1234, 3'd5, 16'h0000, 4'b1100);
        dir32("sra32", 4'd6, 32'h8000_0000, 32'd31, 32'hffff_ffff, 4'b0010);
        dir32("sll32", 4'd3, 32'h0000_0001, 32'd31, 32'h8000_0000, 4'b0010);

        // Back-to-back with the consumer stalled for several cycles, then drain.
        enable = 1'b1;
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1;
            in_op = 4'($urandom_range(0, 8));
            in_a = 16'($urandom); in_b = 16'($urandom); in_tag = 3'(i);
            out_ready = (i >= 5);
            step();
        end
        in_valid = 1'b0;
        repeat (3) step();

        // Reset with two operations in flight: neither may ever emerge.
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_op = 4'd1; in_a = 16'h00f0 << i; in_b = 16'h0f00; in_tag = 3'(6 + i);
            step();
        end
        check_eq("pre_rst_valid", out_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_valid", out_valid, 1'b0);
        check_eq("async_rst_result", out_result, 16'h0);
        check_eq("async_rst_tag", out_tag, 3'd0);
        check_eq("async_rst_flags", {out_illegal, out_zf, out_nf, out_cf}, 4'b0000);
        sb.delete();
        in_valid = 1'b0; out_ready = 1'b1;
        #2 rst_n = 1'b1;
        repeat (3) step();
        in_valid = 1'b1; in_op = 4'd2; in_a = 16'h5a5a; in_b = 16'hffff; in_tag = 3'd3;
        step();
        in_valid = 1'b0;
        repeat (3) step();

        // Randomized traffic with random enable and backpressure.
        for (int n = 0; n < 500; n++) begin
            enable    = ($urandom_range(0, 9) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            in_valid  = ($urandom_range(0, 9) < 8);
            if ($urandom_range(0, 7) == 0) in_op = 4'($urandom_range(9, 15));
            else                           in_op = 4'($urandom_range(0, 8));
            in_a = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
            in_b = 16'($urandom);
            if ($urandom_range(0, 5) == 0) in_b[3:0] = 4'h0;
            in_tag = 3'($urandom);
            step();
        end

        enable = 1'b1; out_ready = 1'b1; in_valid = 1'b0;
        repeat (4) step();
        check_eq("drain_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
